// File: rtl/crash_pkg.sv
// crash_pkg: shared state encoding and frame counter width for the crash response slice
package crash_pkg;
  typedef enum logic [1:0] {IDLE, CRASH, RECOVER, GAME_OVER} crash_state_t;
  localparam int FRAME_CNT_W = 8;
endpackage

// File: rtl/frame_timer.sv
// frame_timer: counts frame ticks up to a terminal value, pulses done on the terminal tick and restarts at 0
module frame_timer
  import crash_pkg::*;
(
  input  logic                   clk,
  input  logic                   resetN,
  input  logic                   clear_i,
  input  logic                   tick_i,
  input  logic [FRAME_CNT_W-1:0] term_i,
  output logic [FRAME_CNT_W-1:0] count_o,
  output logic                   done_o
);
  logic [FRAME_CNT_W-1:0] count_q, count_d;
  assign done_o  = tick_i && !clear_i && count_q == term_i;
  assign count_d = (clear_i || done_o) ? '0 : tick_i ? count_q + FRAME_CNT_W'(1) : count_q;
  assign count_o = count_q;
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) count_q <= '0;
    else count_q <= count_d;
endmodule

// File: rtl/crash_response_ctrl.sv
// crash_response_ctrl: turns collision levels into freeze, life loss, blinking recovery and game over
module crash_response_ctrl
  import crash_pkg::*;
#(
  parameter int LIVES_INIT     = 3,
  parameter int LIVES_W        = 2,
  parameter int CRASH_FRAMES   = 60,
  parameter int RECOVER_FRAMES = 90,
  parameter int BLINK_FRAMES   = 8
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame,
  input  logic               collision,
  input  logic               road_collision,
  input  logic               restart,
  output logic               crash_pulse,
  output logic               player_freeze,
  output logic               invulnerable,
  output logic               blink_hide,
  output logic [LIVES_W-1:0] lives,
  output logic               game_over
);
  crash_state_t state_q, state_d;
  logic [LIVES_W-1:0] lives_q, lives_d;
  logic blink_q, blink_d, pulse_q, pulse_d, freeze_q, invul_q, over_q;
  logic [FRAME_CNT_W-1:0] cnt, term;
  logic done, hit, blink_edge, timing;
  assign hit        = collision | road_collision;
  assign timing     = state_q == CRASH || state_q == RECOVER;
  assign term       = state_q == CRASH ? FRAME_CNT_W'(CRASH_FRAMES - 1) : FRAME_CNT_W'(RECOVER_FRAMES - 1);
  assign blink_edge = ((9'(cnt) + 9'd1) % 9'(BLINK_FRAMES)) == 9'd0;
  // The timer only runs in CRASH/RECOVER, so a hit coinciding with a frame tick in IDLE is never counted
  frame_timer u_timer (
    .clk     (clk),
    .resetN  (resetN),
    .clear_i (restart || !timing),
    .tick_i  (startOfFrame),
    .term_i  (term),
    .count_o (cnt),
    .done_o  (done)
  );
  always_comb begin
    state_d = state_q;
    lives_d = lives_q;
    blink_d = blink_q;
    pulse_d = 1'b0;
    if (restart) begin
      state_d = IDLE;
      lives_d = LIVES_W'(LIVES_INIT);
      blink_d = 1'b0;
    end else
      case (state_q)
        IDLE:
          if (hit) begin
            state_d = CRASH;
            pulse_d = 1'b1;
            lives_d = lives_q == '0 ? '0 : lives_q - LIVES_W'(1);
          end
        CRASH:
          if (done) begin
            state_d = lives_q == '0 ? GAME_OVER : RECOVER;
            blink_d = 1'b0;
          end
        RECOVER:
          if (done) begin
            state_d = IDLE;
            blink_d = 1'b0;
          end else if (startOfFrame && blink_edge) blink_d = !blink_q;
        default: lives_d = '0;
      endcase
  end
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) begin
      state_q  <= IDLE;
      lives_q  <= LIVES_W'(LIVES_INIT);
      blink_q  <= 1'b0;
      pulse_q  <= 1'b0;
      freeze_q <= 1'b0;
      invul_q  <= 1'b0;
      over_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      lives_q  <= lives_d;
      blink_q  <= blink_d;
      pulse_q  <= pulse_d;
      freeze_q <= state_d == CRASH || state_d == GAME_OVER;
      invul_q  <= state_d == RECOVER;
      over_q   <= state_d == GAME_OVER;
    end
  assign crash_pulse   = pulse_q;
  assign player_freeze = freeze_q;
  assign invulnerable  = invul_q;
  assign blink_hide    = blink_q;
  assign lives         = lives_q;
  assign game_over     = over_q;
endmodule

// File: tb/tb_crash_response_ctrl.sv
// tb_crash_response_ctrl: directed crash scenarios checked against a frame-level behavioural model
module tb_crash_response_ctrl;
  localparam int LI = 3, CF = 60, RF = 90, BF = 8;
  localparam int M_IDLE = 0, M_CRASH = 1, M_REC = 2, M_OVER = 3;
  logic clk = 1'b0, resetN = 1'b0, sof = 1'b0, col = 1'b0, rcol = 1'b0, rs = 1'b0;
  logic crash_pulse, player_freeze, invulnerable, blink_hide, game_over;
  logic [1:0] lives;
  int total = 0, bad = 0, pulses = 0;
  int m_mode = M_IDLE, m_lives = LI, m_left = 0, m_elapsed = 0, m_hide = 0, m_pulse = 0;
  always #5 clk = ~clk;
  crash_response_ctrl #(
    .LIVES_INIT(LI), .LIVES_W(2), .CRASH_FRAMES(CF), .RECOVER_FRAMES(RF), .BLINK_FRAMES(BF)
  ) dut (
    .clk(clk), .resetN(resetN), .startOfFrame(sof), .collision(col), .road_collision(rcol),
    .restart(rs), .crash_pulse(crash_pulse), .player_freeze(player_freeze),
    .invulnerable(invulnerable), .blink_hide(blink_hide), .lives(lives), .game_over(game_over)
  );
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d at %0t", nm, act, exp, $time);
    end
  endtask
  // Model: crash is a countdown of frames, blink phase is elapsed recovery frames divided by the half-period
  initial forever begin
    @(posedge clk);
    m_pulse = 0;
    if (!resetN) begin
      m_mode = M_IDLE; m_lives = LI; m_hide = 0;
    end else if (rs) begin
      m_mode = M_IDLE; m_lives = LI; m_hide = 0;
    end else if (m_mode == M_IDLE) begin
      if (col || rcol) begin
        m_mode = M_CRASH; m_left = CF; m_pulse = 1;
        m_lives = m_lives > 0 ? m_lives - 1 : 0;
      end
    end else if (m_mode == M_CRASH) begin
      if (sof) begin
        m_left--;
        if (m_left == 0) begin
          m_mode = m_lives == 0 ? M_OVER : M_REC; m_elapsed = 0; m_hide = 0;
        end
      end
    end else if (m_mode == M_REC && sof) begin
      m_elapsed++;
      if (m_elapsed == RF) begin
        m_mode = M_IDLE; m_hide = 0;
      end else m_hide = (m_elapsed / BF) % 2;
    end
    #1;
    check("m_pulse", 32'(crash_pulse), 32'(m_pulse));
    check("m_freeze", 32'(player_freeze), 32'(m_mode == M_CRASH || m_mode == M_OVER));
    check("m_invul", 32'(invulnerable), 32'(m_mode == M_REC));
    check("m_over", 32'(game_over), 32'(m_mode == M_OVER));
    check("m_blink", 32'(blink_hide), 32'(m_hide));
    check("m_lives", 32'(lives), 32'(m_lives));
    if (crash_pulse === 1'b1) pulses++;
  end
  task automatic step(input logic s, input logic c, input logic rc, input logic r);
    @(negedge clk);
    sof = s; col = c; rcol = rc; rs = r;
    @(posedge clk);
    #2;
  endtask
  task automatic frame(input logic c, input logic rc);
    step(1'b1, c, rc, 1'b0);
    repeat (3) step(1'b0, c, rc, 1'b0);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
  initial begin
    int n, tog, first, last, p0;
    logic prev;
    repeat (2) @(posedge clk);
    #2;
    check("rst_lives", 32'(lives), 3);
    check("rst_outs", 32'({crash_pulse, player_freeze, invulnerable, blink_hide, game_over}), 0);
    @(negedge clk) resetN = 1'b1;
    // single car hit, freeze length, then recovery blink pattern
    step(0, 1, 0, 0);
    check("t1_pulse", 32'(crash_pulse), 1);
    check("t1_lives", 32'(lives), 2);
    check("t1_freeze", 32'(player_freeze), 1);
    step(0, 0, 0, 0);
    check("t1_pulse_once", 32'(crash_pulse), 0);
    n = 0;
    while (player_freeze === 1'b1 && n < 200) begin frame(0, 0); n++; end
    check("t1_freeze_frames", 32'(n), CF);
    check("t1_invul", 32'(invulnerable), 1);
    n = 0; tog = 0; first = 0; last = 0; prev = blink_hide;
    while (invulnerable === 1'b1 && n < 200) begin
      frame(0, 0); n++;
      if (invulnerable === 1'b1 && blink_hide !== prev) begin
        tog++; if (first == 0) first = n; last = n; prev = blink_hide;
      end
    end
    check("t2_rec_frames", 32'(n), RF);
    check("t2_toggles", 32'(tog), 11);
    check("t2_first", 32'(first), 8);
    check("t2_last", 32'(last), 88);
    check("t2_blink_end", 32'(blink_hide), 0);
    check("t2_lives", 32'(lives), 2);
    // held collision: one life per crash, re-crash right after recovery
    p0 = pulses;
    step(0, 1, 0, 0);
    check("t3_lives", 32'(lives), 1);
    repeat (CF + RF) frame(1, 0);
    check("t3_pulses", 32'(pulses - p0), 2);
    check("t3_lives0", 32'(lives), 0);
    check("t3_freeze", 32'(player_freeze), 1);
    repeat (CF) frame(0, 0);
    check("t4_over", 32'(game_over), 1);
    check("t4_freeze", 32'(player_freeze), 1);
    p0 = pulses;
    repeat (3) step(0, 1, 1, 0);
    repeat (2) frame(1, 0);
    check("t4_no_pulse", 32'(pulses - p0), 0);
    check("t4_still_over", 32'(game_over), 1);
    // restart from game over and mid-crash
    step(0, 0, 0, 1);
    check("t5_over", 32'(game_over), 0);
    check("t5_freeze", 32'(player_freeze), 0);
    check("t5_lives", 32'(lives), 3);
    step(0, 1, 0, 0);
    check("t5_crash_lives", 32'(lives), 2);
    repeat (10) frame(0, 0);
    step(1, 1, 0, 1);
    check("t5_mid_freeze", 32'(player_freeze), 0);
    check("t5_mid_lives", 32'(lives), 3);
    check("t5_mid_pulse", 32'(crash_pulse), 0);
    // road hit coincident with frame tick, then async reset mid-recovery
    step(1, 0, 1, 0);
    check("t6_pulse", 32'(crash_pulse), 1);
    check("t6_lives", 32'(lives), 2);
    n = 0;
    while (player_freeze === 1'b1 && n < 200) begin frame(0, 0); n++; end
    check("t6_freeze_frames", 32'(n), CF);
    repeat (10) frame(0, 0);
    check("t6_blink", 32'(blink_hide), 1);
    check("t6_invul", 32'(invulnerable), 1);
    @(negedge clk);
    #1 resetN = 1'b0;
    #1;
    check("t6_rst_invul", 32'(invulnerable), 0);
    check("t6_rst_blink", 32'(blink_hide), 0);
    check("t6_rst_lives", 32'(lives), 3);
    check("t6_rst_freeze", 32'(player_freeze), 0);
    @(negedge clk) resetN = 1'b1;
    step(0, 0, 0, 0);
    check("t6_post_lives", 32'(lives), 3);
    check("t6_post_invul", 32'(invulnerable), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
